// File: rtl/fe_tx_framer.sv
// -----------------------------------------------------------------------------
// fe_tx_framer
//
// Transmit-side framer for the UART FIFO link. Emits a frame in the order the
// front-end receiver parses it:
//   count[15:8], count[7:0], command, then `count` payload bytes
// Payload bytes are pulled one at a time from the TX FIFO. Every byte is
// offered to the UART TX serializer over a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle frame request, honoured only when idle
//   cmd        in   [7:0]  command byte, sampled with start
//   tx_cnt     in   [15:0] payload byte count, sampled with start
//   fifo_empty in   TX FIFO empty flag
//   fifo_rd    out  FIFO read strobe (combinational)
//   fifo_dout  in   [7:0]  FIFO data, valid the cycle after fifo_rd
//   tx_valid   out  byte offered to UART TX (registered)
//   tx_data    out  [7:0]  byte offered (registered)
//   tx_ready   in   UART TX accepts when tx_valid & tx_ready
//   busy       out  high whenever a frame is in progress
//   done       out  one-cycle pulse after the final byte is accepted
// -----------------------------------------------------------------------------
module fe_tx_framer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [15:0] tx_cnt,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_dout,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        RD    = 3'd2,
        LATCH = 3'd3,
        SEND  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cmd_reg,   cmd_next;
    logic [15:0] rem_reg,   rem_next;
    logic [1:0]  hidx_reg,  hidx_next;
    logic        valid_reg, valid_next;
    logic [7:0]  data_reg,  data_next;
    logic        accept;

    assign accept   = valid_reg & tx_ready;
    assign fifo_rd  = (state_reg == RD) & ~fifo_empty;
    assign tx_valid = valid_reg;
    assign tx_data  = data_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cmd_reg   <= 8'h00;
            rem_reg   <= 16'h0000;
            hidx_reg  <= 2'd0;
            valid_reg <= 1'b0;
            data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            rem_reg   <= rem_next;
            hidx_reg  <= hidx_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        rem_next   = rem_reg;
        hidx_next  = hidx_reg;
        valid_next = valid_reg;
        data_next  = data_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    cmd_next   = cmd;
                    rem_next   = tx_cnt;
                    hidx_next  = 2'd0;
                    data_next  = tx_cnt[15:8];
                    valid_next = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                // rem is untouched during the header, so its low byte is
                // still the sampled count low byte.
                if (accept) begin
                    case (hidx_reg)
                        2'd0: begin
                            data_next = rem_reg[7:0];
                            hidx_next = 2'd1;
                        end
                        2'd1: begin
                            data_next = cmd_reg;
                            hidx_next = 2'd2;
                        end
                        default: begin
                            valid_next = 1'b0;
                            state_next = (rem_reg != 16'd0) ? RD : DONE;
                        end
                    endcase
                end
            end
            RD: begin
                // fifo_rd is driven combinationally from this state.
                if (!fifo_empty) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                data_next  = fifo_dout;
                valid_next = 1'b1;
                rem_next   = rem_reg - 16'd1;
                state_next = SEND;
            end
            SEND: begin
                if (accept) begin
                    valid_next = 1'b0;
                    state_next = (rem_reg != 16'd0) ? RD : DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fe_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_fe_tx_framer
//
// Directed testbench for fe_tx_framer. A small FIFO model feeds payload bytes,
// a monitor records every accepted byte with its cycle number, and all
// comparisons go through the check task.
// -----------------------------------------------------------------------------
module tb_fe_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cmd;
    logic [15:0] tx_cnt;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_dout = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    fe_tx_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd        (cmd),
        .tx_cnt     (tx_cnt),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    // FIFO model: registered read data, one cycle after fifo_rd
    logic [7:0] fifo_mem [0:1023];
    logic [9:0] wr_ptr = 10'd0;
    logic [9:0] rd_ptr = 10'd0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
        end
    end

    // Monitor
    int         cyc = 0;
    logic [7:0] cap_data [0:2047];
    int         cap_cyc  [0:2047];
    int         cap_n = 0;
    int         rd_n = 0;
    int         done_n = 0;
    int         last_done_cyc = 0;
    int         stab_err = 0;
    int         rd_empty_err = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) begin
            cap_data[cap_n[10:0]] <= tx_data;
            cap_cyc[cap_n[10:0]]  <= cyc;
            cap_n <= cap_n + 1;
        end
        if (pend && rst_n && (!tx_valid || tx_data != pend_data))
            stab_err <= stab_err + 1;
        pend      <= tx_valid && !tx_ready;
        pend_data <= tx_data;
        if (fifo_rd) rd_n <= rd_n + 1;
        if (fifo_rd && fifo_empty) rd_empty_err <= rd_empty_err + 1;
        if (done) begin
            done_n        <= done_n + 1;
            last_done_cyc <= cyc;
        end
    end

    int checks_n = 0;
    int errors_n = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic start_frame(input logic [7:0] c, input logic [15:0] n, output int s);
        @(negedge clk);
        start  = 1'b1;
        cmd    = c;
        tx_cnt = n;
        s      = cyc;
        @(negedge clk);
        start  = 1'b0;
        // later changes to cmd/tx_cnt must not leak into the frame
        cmd    = ~c;
        tx_cnt = n + 16'd7;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int k;
        k = 0;
        while (done_n == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done_n - d0), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_stream(input int b, input string tag);
        check({tag, "_len"}, 32'(cap_n - b), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(cap_data[11'(b + i)]), 32'(exp_q[i]));
        $display("frame %s: %0d bytes observed, %0d expected", tag, cap_n - b, exp_q.size());
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    bit bp_on;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, b, d0, r0, k;

        rst_n    = 1'b0;
        start    = 1'b0;
        cmd      = 8'h00;
        tx_cnt   = 16'h0000;
        tx_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_fifo_rd",  32'(fifo_rd),  32'd0);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);

        // Header-only frame
        b = cap_n; d0 = done_n; r0 = rd_n;
        start_frame(8'hA5, 16'd0, s);
        wait_done(d0, 50, "hdr_done");
        exp_q = '{8'h00, 8'h00, 8'hA5};
        check_stream(b, "hdr");
        for (int i = 0; i < 3; i++)
            check($sformatf("hdr_cyc%0d", i), 32'(cap_cyc[11'(b + i)]), 32'(s + 1 + i));
        check("hdr_done_cyc", 32'(last_done_cyc), 32'(s + 4));
        check("hdr_rd_n", 32'(rd_n - r0), 32'd0);
        check("hdr_busy_low", 32'(busy), 32'd0);

        // Three-byte payload
        push(8'h11); push(8'h22); push(8'h33);
        b = cap_n; d0 = done_n; r0 = rd_n;
        start_frame(8'h3C, 16'd3, s);
        wait_done(d0, 100, "p3_done");
        exp_q = '{8'h00, 8'h03, 8'h3C, 8'h11, 8'h22, 8'h33};
        check_stream(b, "p3");
        check("p3_rd_n", 32'(rd_n - r0), 32'd3);
        check("p3_last_cyc", 32'(cap_cyc[11'(b + 5)]), 32'(s + 12));
        check("p3_done_cyc", 32'(last_done_cyc), 32'(s + 13));
        check("p3_fifo_empty", 32'(fifo_empty), 32'd1);

        // Backpressure, 258 payload bytes
        for (int i = 0; i < 258; i++) push(pat(i));
        b = cap_n; d0 = done_n; r0 = rd_n;
        start_frame(8'h01, 16'h0102, s);
        bp_on = 1'b1;
        fork
            begin
                wait_done(d0, 6000, "bp_done");
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(negedge clk);
                    tx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        tx_ready = 1'b1;
        exp_q = '{8'h01, 8'h02, 8'h01};
        for (int i = 0; i < 258; i++) exp_q.push_back(pat(i));
        check_stream(b, "bp");
        check("bp_rd_n", 32'(rd_n - r0), 32'd258);
        check("bp_stable", 32'(stab_err), 32'd0);

        // FIFO underflow stall
        push(8'h77);
        b = cap_n; d0 = done_n;
        start_frame(8'h55, 16'd2, s);
        repeat (20) @(negedge clk);
        check("uf_bytes_before", 32'(cap_n - b), 32'd4);
        check("uf_valid_low", 32'(tx_valid), 32'd0);
        check("uf_busy", 32'(busy), 32'd1);
        check("uf_fifo_rd_low", 32'(fifo_rd), 32'd0);
        push(8'h88);
        wait_done(d0, 100, "uf_done");
        exp_q = '{8'h00, 8'h02, 8'h55, 8'h77, 8'h88};
        check_stream(b, "uf");

        // Start while busy
        push(8'hAA); push(8'hBB);
        b = cap_n; d0 = done_n;
        start_frame(8'h42, 16'd2, s);
        repeat (3) @(negedge clk);
        start = 1'b1; cmd = 8'h99; tx_cnt = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 100, "sb_done");
        repeat (10) @(negedge clk);
        exp_q = '{8'h00, 8'h02, 8'h42, 8'hAA, 8'hBB};
        check_stream(b, "sb");
        check("sb_done_once", 32'(done_n - d0), 32'd1);
        check("sb_busy_low", 32'(busy), 32'd0);

        // Reset mid-payload
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        b = cap_n;
        start_frame(8'h10, 16'd4, s);
        k = 0;
        while (!((cap_n - b) == 3 && tx_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rm_reach_send", 32'(((cap_n - b) == 3) && tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rm_tx_valid", 32'(tx_valid), 32'd0);
        check("rm_tx_data",  32'(tx_data),  32'd0);
        check("rm_busy",     32'(busy),     32'd0);
        check("rm_done",     32'(done),     32'd0);
        check("rm_fifo_rd",  32'(fifo_rd),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rm_abandoned", 32'(cap_n - b), 32'd3);
        b = cap_n; d0 = done_n; r0 = rd_n;
        start_frame(8'h20, 16'd3, s);
        wait_done(d0, 100, "rm2_done");
        exp_q = '{8'h00, 8'h03, 8'h20, 8'hC2, 8'hC3, 8'hC4};
        check_stream(b, "rm2");
        check("rm2_rd_n", 32'(rd_n - r0), 32'd3);

        check("rd_while_empty", 32'(rd_empty_err), 32'd0);
        check("stable_overall", 32'(stab_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/fe_tx_framer.md
# fe_tx_framer

Transmit-side framer for the UART FIFO link. It builds outgoing frames in the same byte order the front-end receiver parses: 16-bit count high byte, count low byte, command byte, then `count` payload bytes. Payload bytes are pulled from the TX FIFO, and every byte goes to the UART transmitter over a valid/ready handshake. It sits between the control logic, which issues `start`, and the UART TX serializer.

## Interface
Parameters:
- none; all widths are fixed at 8-bit data and a 16-bit count.

Ports:
- `clk` in 1: system clock; every register updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to send a frame. Honoured only in IDLE.
- `cmd` in 8: command byte. Sampled when `start` is accepted.
- `tx_cnt` in 16: payload byte count. Sampled when `start` is accepted.
- `fifo_empty` in 1: TX FIFO empty flag.
- `fifo_rd` out 1: FIFO read strobe, combinational, equal to (state==RD) & !fifo_empty.
- `fifo_dout` in 8: FIFO read data, valid the cycle after `fifo_rd`.
- `tx_valid` out 1: byte offered to the UART TX; registered.
- `tx_data` out 8: byte offered; registered.
- `tx_ready` in 1: UART TX accepts a byte when `tx_valid` & `tx_ready` are both high.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: single-cycle pulse, asserted in the DONE state.

## Operation
- States: IDLE, HDR, RD, LATCH, SEND, DONE.
- IDLE, on `start`:
  - latch `cmd` into `cmd_q` and `tx_cnt` into `rem`;
  - set `hidx`=0, load `tx_data`=tx_cnt[15:8], set `tx_valid`=1;
  - go to HDR.
- HDR: hold `tx_valid`/`tx_data` until accepted. Each accept advances `hidx`:
  - `hidx` 0 -> load cnt[7:0];
  - `hidx` 1 -> load `cmd_q`;
  - `hidx` 2 -> drop `tx_valid`; go to RD if `rem`!=0, otherwise go to DONE.
- RD: wait while `fifo_empty`. Otherwise pulse `fifo_rd` for one cycle and go to LATCH.
- LATCH: `tx_data`<=`fifo_dout`, `tx_valid`<=1, `rem`<=rem-1; go to SEND.
- SEND: hold until accept. On accept drop `tx_valid`; go to RD if `rem`!=0, otherwise go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `rem` is a 16-bit unsigned down-counter. `tx_cnt`=0 sends a 3-byte header-only frame. `tx_cnt`=16'hFFFF sends 65535 payload bytes without wrap.
- `start` while `busy` is ignored. `cmd` and `tx_cnt` changing mid-frame have no effect.
- An empty FIFO mid-payload stalls in RD indefinitely; no byte is skipped, no timeout.
- `tx_data` stays stable while `tx_valid` is high and not yet accepted.
- `tx_ready` while `tx_valid`=0 is ignored.
- Reset at any point returns to IDLE immediately. Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, `fifo_rd`=0. The partial frame is abandoned and no FIFO read is replayed.

## Timing
- Start accepted at edge 0: `tx_valid`=1 with cnt[15:8] in cycle 1.
- Header bytes can go back-to-back: with `tx_ready` held high, the three header bytes are accepted in cycles 1, 2, 3.
- Payload per byte, with FIFO non-empty and `tx_ready` high:
  - RD (`fifo_rd`) in cycle n;
  - LATCH in n+1;
  - SEND with `tx_valid` in n+2, accepted there;
  - next RD in n+3.
  - Throughput is therefore 1 byte per 3 cycles.
- `done` is high the cycle after the final accept; `busy` falls the cycle after that.
- Minimum turnaround: `start` can be accepted in the cycle `busy` is first low.
- Total length for N payload bytes with `tx_ready`=1 and a non-empty FIFO: 3 + 3N cycles from cycle 1 to the final accept.

## Test plan
- **Header-only frame:** `start` with cmd=8'hA5, tx_cnt=0, `tx_ready`=1 -> bytes 00,00,A5 accepted in cycles 1-3; `done` in cycle 4; `fifo_rd` never high.
- **Three-byte payload:** FIFO preloaded with 11,22,33; cmd=8'h3C, tx_cnt=3 -> byte stream 00,03,3C,11,22,33; exactly 3 `fifo_rd` pulses; `done` once.
- **Backpressure:** `tx_ready` toggles randomly, cmd=8'h01, tx_cnt=16'h0102 -> `tx_data` stable while valid and unaccepted; exactly 258 payload bytes, all in FIFO order; header bytes 01,02,01.
- **FIFO underflow stall:** tx_cnt=2, FIFO holds 1 byte; push the second byte 20 cycles later -> framer waits in RD with `fifo_rd`=0 while empty, then finishes correctly.
- **Start while busy:** a second `start` with different cmd/tx_cnt mid-frame -> ignored; the first frame's bytes are unchanged; only one `done`.
- **Reset mid-payload:** assert `rst_n` low during SEND -> all outputs 0 immediately; after release, a new `start` sends a correct full frame.
